// File: rtl/swap_write_buffer_if.sv
// Bundle of the two cache write ports, the swap select and the memory-side
// drain handshake of the posted-write buffer.
interface swap_write_buffer_if;
  logic        swc;
  logic        a_en,     b_en;
  logic [26:0] a_adr,    b_adr;
  logic [31:0] a_data,   b_data;
  logic [3:0]  a_byteen, b_byteen;
  logic        a_done,   b_done;
  logic [26:0] memadr;
  logic [31:0] memdata;
  logic [3:0]  membyteen;
  logic        memen;
  logic        memdone;

  // buffer side
  modport slave (
    input  swc, a_en, b_en, a_adr, b_adr, a_data, b_data, a_byteen, b_byteen, memdone,
    output a_done, b_done, memadr, memdata, membyteen, memen
  );

  // requester / memory-controller side
  modport master (
    output swc, a_en, b_en, a_adr, b_adr, a_data, b_data, a_byteen, b_byteen, memdone,
    input  a_done, b_done, memadr, memdata, membyteen, memen
  );
endinterface

// File: rtl/swap_write_buffer.sv
// Four-entry circular posted-write buffer: the port picked by swc enqueues,
// the head entry drains in order under memen/memdone.
module swap_write_buffer (
  input  logic              ph1,
  input  logic              reset,
  swap_write_buffer_if.slave bus
);
  localparam int ENTRIES = 4;
  localparam int EW      = 63;   // {byteen[3:0], adr[26:0], data[31:0]}

  logic               en;
  logic [26:0]        adr;
  logic [31:0]        data;
  logic [3:0]         byteen;
  logic [1:0]         wptr, rptr;
  logic [ENTRIES-1:0] valid, valid_nxt, wr_oh, rd_oh;
  logic [ENTRIES-1:0][EW-1:0] ent, ent_nxt;
  logic [EW-1:0]      head;
  logic               done, push, pop, memen;

  // port swap
  always_comb begin
    en     = bus.swc ? bus.b_en     : bus.a_en;
    adr    = bus.swc ? bus.b_adr    : bus.a_adr;
    data   = bus.swc ? bus.b_data   : bus.a_data;
    byteen = bus.swc ? bus.b_byteen : bus.a_byteen;
  end

  assign wr_oh = 4'b0001 << wptr;
  assign rd_oh = 4'b0001 << rptr;

  // done/memen come only from registered state, never from en or memdone
  assign done  = ~valid[wptr];
  assign memen = valid[rptr];
  assign push  = en & done;
  assign pop   = memen & bus.memdone;

  // push and pop can never address the same entry: one needs it empty, the other valid
  always_comb begin
    valid_nxt = valid;
    ent_nxt   = ent;
    for (int i = 0; i < ENTRIES; i++) begin
      if (push && wr_oh[i]) begin
        valid_nxt[i] = 1'b1;
        ent_nxt[i]   = {byteen, adr, data};
      end else if (pop && rd_oh[i]) begin
        valid_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= '0;
      ent   <= '0;
    end else begin
      valid <= valid_nxt;
      ent   <= ent_nxt;
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
    end
  end

  assign head          = ent[rptr];
  assign bus.memadr    = head[58:32];
  assign bus.memdata   = head[31:0];
  assign bus.membyteen = head[62:59];
  assign bus.memen     = memen;
  assign bus.a_done    = ~bus.swc & done;
  assign bus.b_done    =  bus.swc & done;
endmodule

// File: tb/tb_swap_write_buffer.sv
// Bench for swap_write_buffer: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_swap_write_buffer;
  logic ph1 = 1'b0;
  logic reset;
  swap_write_buffer_if bif ();

  swap_write_buffer dut (.ph1(ph1), .reset(reset), .bus(bif));

  always #5 ph1 = ~ph1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        swc, a_en, b_en, md;
    logic [26:0] a_adr;
    logic [31:0] a_dat;
    logic [26:0] b_adr;
    logic [31:0] b_dat;
    logic        e_memen;
    logic [26:0] e_adr;
    logic [31:0] e_dat;
    logic        e_ad, e_bd;
  } vec_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [26:0] adr;
    logic [31:0] dat;
  } ent_t;

  vec_t vt[23];
  ent_t q[$];

  function automatic vec_t mk(logic swc, logic a_en, logic b_en, logic md,
                              logic [26:0] a_adr, logic [31:0] a_dat,
                              logic [26:0] b_adr, logic [31:0] b_dat,
                              logic e_memen, logic [26:0] e_adr, logic [31:0] e_dat,
                              logic e_ad, logic e_bd);
    vec_t v;
    v.swc = swc; v.a_en = a_en; v.b_en = b_en; v.md = md;
    v.a_adr = a_adr; v.a_dat = a_dat; v.b_adr = b_adr; v.b_dat = b_dat;
    v.e_memen = e_memen; v.e_adr = e_adr; v.e_dat = e_dat; v.e_ad = e_ad; v.e_bd = e_bd;
    return v;
  endfunction

  task automatic idle_inputs();
    bif.swc = 0; bif.a_en = 0; bif.b_en = 0; bif.memdone = 0;
    bif.a_adr = '0; bif.b_adr = '0; bif.a_data = '0; bif.b_data = '0;
    bif.a_byteen = 4'hF; bif.b_byteen = 4'h3;
  endtask

  task automatic do_reset();
    @(negedge ph1);
    idle_inputs();
    reset = 0;
    #1;
    chk("rst_memen",  bif.memen, 0);
    chk("rst_memadr", bif.memadr, 0);
    chk("rst_memdat", bif.memdata, 0);
    chk("rst_membe",  bif.membyteen, 0);
    chk("rst_a_done", bif.a_done, 1);
    chk("rst_b_done", bif.b_done, 0);
    @(negedge ph1);
    reset = 1;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    // vectors: inputs driven for one cycle, outputs expected before that cycle's edge
    vt[0]  = mk(0,0,0,0, 27'h0,  32'h0,        27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);
    vt[1]  = mk(0,1,0,0, 27'h10, 32'hDEADBEEF, 27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);
    vt[2]  = mk(0,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h10, 32'hDEADBEEF, 1,0);
    vt[3]  = mk(0,0,0,0, 27'h0,  32'h0,        27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);
    vt[4]  = mk(0,1,0,0, 27'h101,32'h1,        27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);
    vt[5]  = mk(0,1,0,0, 27'h102,32'h2,        27'h0,  32'h0,        1, 27'h101,32'h1,        1,0);
    vt[6]  = mk(0,1,0,0, 27'h103,32'h3,        27'h0,  32'h0,        1, 27'h101,32'h1,        1,0);
    vt[7]  = mk(0,1,0,0, 27'h104,32'h4,        27'h0,  32'h0,        1, 27'h101,32'h1,        1,0);
    vt[8]  = mk(0,1,0,0, 27'h105,32'h5,        27'h0,  32'h0,        1, 27'h101,32'h1,        0,0);
    vt[9]  = mk(0,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h101,32'h1,        0,0);
    vt[10] = mk(0,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h102,32'h2,        1,0);
    vt[11] = mk(0,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h103,32'h3,        1,0);
    vt[12] = mk(0,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h104,32'h4,        1,0);
    vt[13] = mk(0,0,0,0, 27'h0,  32'h0,        27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);
    vt[14] = mk(1,1,1,0, 27'h20, 32'h11111111, 27'h30, 32'hCAFEF00D, 0, 27'h0,  32'h0,        0,1);
    vt[15] = mk(1,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h30, 32'hCAFEF00D, 0,1);
    vt[16] = mk(0,0,0,0, 27'h0,  32'h0,        27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);
    vt[17] = mk(0,1,0,0, 27'h41, 32'hA1,       27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);
    vt[18] = mk(0,1,0,0, 27'h42, 32'hA2,       27'h0,  32'h0,        1, 27'h41, 32'hA1,       1,0);
    vt[19] = mk(0,1,0,1, 27'h43, 32'hA3,       27'h0,  32'h0,        1, 27'h41, 32'hA1,       1,0);
    vt[20] = mk(0,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h42, 32'hA2,       1,0);
    vt[21] = mk(0,0,0,1, 27'h0,  32'h0,        27'h0,  32'h0,        1, 27'h43, 32'hA3,       1,0);
    vt[22] = mk(0,0,0,0, 27'h0,  32'h0,        27'h0,  32'h0,        0, 27'h0,  32'h0,        1,0);

    do_reset();

    foreach (vt[i]) begin
      @(negedge ph1);
      bif.swc = vt[i].swc; bif.a_en = vt[i].a_en; bif.b_en = vt[i].b_en;
      bif.memdone = vt[i].md;
      bif.a_adr = vt[i].a_adr; bif.a_data = vt[i].a_dat;
      bif.b_adr = vt[i].b_adr; bif.b_data = vt[i].b_dat;
      #1;
      chk($sformatf("vec%0d_memen", i), bif.memen, vt[i].e_memen);
      chk($sformatf("vec%0d_a_done", i), bif.a_done, vt[i].e_ad);
      chk($sformatf("vec%0d_b_done", i), bif.b_done, vt[i].e_bd);
      if (vt[i].e_memen) begin
        chk($sformatf("vec%0d_memadr", i), bif.memadr, vt[i].e_adr);
        chk($sformatf("vec%0d_memdata", i), bif.memdata, vt[i].e_dat);
      end
    end

    // one-at-a-time traffic crossing the pointer wrap
    for (int i = 0; i < 6; i++) begin
      @(negedge ph1);
      idle_inputs();
      bif.a_en = 1; bif.a_adr = 27'h200 + 27'(i); bif.a_data = 32'h10 + 32'(i);
      @(negedge ph1);
      idle_inputs();
      bif.memdone = 1;
      #1;
      chk($sformatf("wrap%0d_memen", i), bif.memen, 1);
      chk($sformatf("wrap%0d_memdata", i), bif.memdata, 32'h10 + 32'(i));
      chk($sformatf("wrap%0d_memadr", i), bif.memadr, 27'h200 + 27'(i));
      @(negedge ph1);
      bif.memdone = 0;
      #1;
      chk($sformatf("wrap%0d_empty", i), bif.memen, 0);
    end

    // reset with three writes queued
    for (int i = 0; i < 3; i++) begin
      @(negedge ph1);
      idle_inputs();
      bif.a_en = 1; bif.a_adr = 27'h300 + 27'(i); bif.a_data = 32'hBAD0 + 32'(i);
    end
    @(negedge ph1);
    idle_inputs();
    #1;
    chk("pre_rst_memen", bif.memen, 1);
    #1;
    reset = 0;
    #1;
    chk("midrst_memen",  bif.memen, 0);
    chk("midrst_memadr", bif.memadr, 0);
    chk("midrst_memdat", bif.memdata, 0);
    @(negedge ph1);
    reset = 1;
    #1;
    chk("postrst_a_done", bif.a_done, 1);
    @(negedge ph1);
    bif.memdone = 1;
    #1;
    chk("postrst_memen", bif.memen, 0);
    @(negedge ph1);
    #1;
    chk("postrst_memen2", bif.memen, 0);

    // randomized run against the queue model
    do_reset();
    q.delete();
    for (int c = 0; c < 600; c++) begin
      logic  sel_en, p_push, p_pop;
      ent_t  e;
      @(negedge ph1);
      if ($urandom_range(0, 9) == 0) bif.swc = ~bif.swc;
      bif.a_en = ($urandom_range(0, 9) < 6);
      bif.b_en = ($urandom_range(0, 9) < 6);
      bif.a_adr = 27'($urandom); bif.b_adr = 27'($urandom);
      bif.a_data = $urandom; bif.b_data = $urandom;
      bif.a_byteen = 4'($urandom); bif.b_byteen = 4'($urandom);
      bif.memdone = ($urandom_range(0, 9) < 5);
      #1;
      chk("rnd_a_done", bif.a_done, !bif.swc && q.size() < 4);
      chk("rnd_b_done", bif.b_done,  bif.swc && q.size() < 4);
      chk("rnd_memen",  bif.memen,   q.size() > 0);
      if (q.size() > 0)
        chk("rnd_head", {bif.membyteen, bif.memadr, bif.memdata}, q[0]);
      sel_en = bif.swc ? bif.b_en : bif.a_en;
      e = bif.swc ? {bif.b_byteen, bif.b_adr, bif.b_data}
                  : {bif.a_byteen, bif.a_adr, bif.a_data};
      p_push = sel_en && q.size() < 4;
      p_pop  = bif.memdone && q.size() > 0;
      if (p_pop)  void'(q.pop_front());
      if (p_push) q.push_back(e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
